// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 10 bits clocked
// out on device clock falls, then ack check and wait for an idle bus.
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_IDLE      | lines released, waiting for tx_start
// S_INHIBIT   | clock held low, data released
// S_REQ       | clock and data held low (start bit)
// S_XFER      | clock released, data bits driven on device clock falls
// S_WAIT_IDLE | lines released, waiting for clock and data both high
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int REQ_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clock_in,
  input  logic       ps2_data_in,
  output logic       ps2_clock_oe,
  output logic       ps2_data_oe
);

  localparam int TMR_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FLT_W   = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {S_IDLE, S_INHIBIT, S_REQ, S_XFER, S_WAIT_IDLE} state_t;

  state_t             state, state_nxt;
  logic [TMR_W-1:0]   tmr, tmr_nxt;
  logic [WD_W-1:0]    wd, wd_nxt;
  logic [3:0]         bit_cnt, bit_nxt;
  logic [9:0]         frame, frame_nxt;
  logic               ack_err, ack_err_nxt;
  logic               clock_oe_nxt, data_oe_nxt, busy_nxt, done_nxt, err_nxt;

  logic [1:0]         clk_sync, dat_sync;
  logic [FLT_W-1:0]   clk_cnt, dat_cnt;
  logic               clk_filt, dat_filt, clk_filt_d;
  logic               fall;

  // Synchronize both raw lines and accept a new level only after it has been stable.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_sync   <= 2'b11;
      dat_sync   <= 2'b11;
      clk_cnt    <= '0;
      dat_cnt    <= '0;
      clk_filt   <= 1'b1;
      dat_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
    end else begin
      clk_sync   <= {clk_sync[0], ps2_clock_in};
      dat_sync   <= {dat_sync[0], ps2_data_in};
      clk_filt_d <= clk_filt;
      if (clk_sync[1] == clk_filt) begin
        clk_cnt <= '0;
      end else if (clk_cnt == FLT_W'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync[1];
        clk_cnt  <= '0;
      end else begin
        clk_cnt <= clk_cnt + 1'b1;
      end
      if (dat_sync[1] == dat_filt) begin
        dat_cnt <= '0;
      end else if (dat_cnt == FLT_W'(FILTER_LEN - 1)) begin
        dat_filt <= dat_sync[1];
        dat_cnt  <= '0;
      end else begin
        dat_cnt <= dat_cnt + 1'b1;
      end
    end
  end

  assign fall = clk_filt_d & ~clk_filt;

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      tmr          <= '0;
      wd           <= '0;
      bit_cnt      <= '0;
      frame        <= '0;
      ack_err      <= 1'b0;
      ps2_clock_oe <= 1'b0;
      ps2_data_oe  <= 1'b0;
      tx_busy      <= 1'b0;
      tx_done      <= 1'b0;
      tx_error     <= 1'b0;
    end else begin
      state        <= state_nxt;
      tmr          <= tmr_nxt;
      wd           <= wd_nxt;
      bit_cnt      <= bit_nxt;
      frame        <= frame_nxt;
      ack_err      <= ack_err_nxt;
      ps2_clock_oe <= clock_oe_nxt;
      ps2_data_oe  <= data_oe_nxt;
      tx_busy      <= busy_nxt;
      tx_done      <= done_nxt;
      tx_error     <= err_nxt;
    end
  end

  // Next-state logic; timers count down to a terminal count of zero.
  always_comb begin
    state_nxt    = state;
    tmr_nxt      = tmr;
    wd_nxt       = wd;
    bit_nxt      = bit_cnt;
    frame_nxt    = frame;
    ack_err_nxt  = ack_err;
    clock_oe_nxt = ps2_clock_oe;
    data_oe_nxt  = ps2_data_oe;
    busy_nxt     = tx_busy;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    case (state)
      S_IDLE: begin
        clock_oe_nxt = 1'b0;
        data_oe_nxt  = 1'b0;
        busy_nxt     = 1'b0;
        if (tx_start) begin
          frame_nxt    = {1'b1, ~^tx_data, tx_data};
          tmr_nxt      = TMR_W'(INHIBIT_CYCLES - 1);
          clock_oe_nxt = 1'b1;
          busy_nxt     = 1'b1;
          ack_err_nxt  = 1'b0;
          state_nxt    = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (tmr == '0) begin
          tmr_nxt     = TMR_W'(REQ_CYCLES - 1);
          data_oe_nxt = 1'b1;
          state_nxt   = S_REQ;
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      S_REQ: begin
        if (tmr == '0) begin
          clock_oe_nxt = 1'b0;
          wd_nxt       = WD_W'(TIMEOUT_CYCLES);
          bit_nxt      = '0;
          state_nxt    = S_XFER;
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      S_XFER: begin
        // A fall takes priority over a watchdog expiry in the same cycle.
        if (fall) begin
          wd_nxt = WD_W'(TIMEOUT_CYCLES);
          if (bit_cnt == 4'd10) begin
            ack_err_nxt = dat_filt;
            data_oe_nxt = 1'b0;
            state_nxt   = S_WAIT_IDLE;
          end else begin
            data_oe_nxt = ~frame[0];
            frame_nxt   = {1'b0, frame[9:1]};
            bit_nxt     = bit_cnt + 1'b1;
          end
        end else if (wd == '0) begin
          clock_oe_nxt = 1'b0;
          data_oe_nxt  = 1'b0;
          done_nxt     = 1'b1;
          err_nxt      = 1'b1;
          busy_nxt     = 1'b0;
          state_nxt    = S_IDLE;
        end else begin
          wd_nxt = wd - 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        clock_oe_nxt = 1'b0;
        data_oe_nxt  = 1'b0;
        if (clk_filt && dat_filt) begin
          done_nxt  = 1'b1;
          err_nxt   = ack_err;
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end else if (fall) begin
          wd_nxt = WD_W'(TIMEOUT_CYCLES);
        end else if (wd == '0) begin
          done_nxt  = 1'b1;
          err_nxt   = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end else begin
          wd_nxt = wd - 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the
// host and the captured bits, phase lengths and completion status are checked
// against values computed from the byte and the device's ack behaviour.
module tb_ps2_host_tx;

  localparam int INH = 200;
  localparam int REQ = 16;
  localparam int TMO = 3000;
  localparam int FLT = 8;
  localparam int H   = 30;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_error;
  logic       ps2_clock_oe, ps2_data_oe;
  logic       ps2_clock_in, ps2_data_in;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;

  int checks = 0;
  int errors = 0;

  assign ps2_clock_in = dev_clk & ~ps2_clock_oe;
  assign ps2_data_in  = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .REQ_CYCLES(REQ),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN(FLT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .tx_data(tx_data),
    .tx_start(tx_start),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .tx_error(tx_error),
    .ps2_clock_in(ps2_clock_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clock_oe(ps2_clock_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  // 100 MHz bench clock.
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bits the device should see on its rising edges: data LSB first, odd parity, stop.
  function automatic logic [9:0] ref_frame(input logic [7:0] d);
    logic par;
    par = ($countones(d) % 2 == 0);
    return {1'b1, par, d};
  endfunction

  // mode: 0 normal, 1 restart attempt mid-frame, 2 clock glitch, 3 reset at bit 4, 4 silent device
  task automatic run_frame(input logic [7:0] d, input bit ack, input int mode);
    logic [9:0] got_bits;
    logic [9:0] exp_bits;
    logic       oe_before;
    int         n;
    exp_bits = ref_frame(d);
    got_bits = '0;
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clock);
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
    check("busy_after_start", {31'd0, tx_busy}, 32'd1);
    n = 0;
    while (ps2_clock_oe && !ps2_data_oe && n < INH + 50) begin
      n++;
      @(negedge clock);
    end
    check("inhibit_len", n, INH);
    n = 0;
    while (ps2_clock_oe && ps2_data_oe && n < REQ + 50) begin
      n++;
      @(negedge clock);
    end
    check("req_len", n, REQ);
    check("start_bit_held", {31'd0, ps2_data_oe}, 32'd1);
    if (mode == 4) begin
      n = 0;
      while (!tx_done && n < TMO + 100) begin
        n++;
        @(negedge clock);
      end
      check("timeout_latency", {31'd0, (n >= TMO && n <= TMO + 2)}, 32'd1);
      check("timeout_lines", {30'd0, ps2_clock_oe, ps2_data_oe}, 32'd0);
      check("timeout_done", {31'd0, tx_done}, 32'd1);
      check("timeout_error", {31'd0, tx_error}, 32'd1);
      @(negedge clock);
      check("timeout_done_pulse", {31'd0, tx_done}, 32'd0);
      return;
    end
    for (int k = 0; k <= 10; k++) begin
      if (mode == 2 && k == 5) begin
        repeat (5) @(negedge clock);
        oe_before = ps2_data_oe;
        dev_clk = 1'b0;
        repeat (3) @(negedge clock);
        dev_clk = 1'b1;
        repeat (15) @(negedge clock);
        check("glitch_data_oe", {31'd0, ps2_data_oe}, {31'd0, oe_before});
        repeat (H - 23) @(negedge clock);
      end else if (mode == 1 && k == 4) begin
        tx_data  = 8'h55;
        tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
        check("busy_mid_frame", {31'd0, tx_busy}, 32'd1);
        repeat (H - 1) @(negedge clock);
      end else begin
        repeat (H) @(negedge clock);
      end
      dev_clk = 1'b0;
      repeat (H) @(negedge clock);
      if (mode == 3 && k == 4) begin
        reset = 1'b1;
        @(negedge clock);
        check("reset_lines", {30'd0, ps2_clock_oe, ps2_data_oe}, 32'd0);
        check("reset_busy_done", {30'd0, tx_busy, tx_done}, 32'd0);
        reset    = 1'b0;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (20) @(negedge clock);
        return;
      end
      dev_clk = 1'b1;
      if (k <= 9) got_bits[k] = ps2_data_in;
      if (k == 9 && ack) dev_data = 1'b0;
      if (k == 10) dev_data = 1'b1;
    end
    check("frame_bits", {22'd0, got_bits}, {22'd0, exp_bits});
    n = 0;
    while (!tx_done && n < 200) begin
      n++;
      @(negedge clock);
    end
    check("done_seen", {31'd0, tx_done}, 32'd1);
    check("tx_error", {31'd0, tx_error}, {31'd0, !ack});
    check("busy_at_done", {31'd0, tx_busy}, 32'd0);
    @(negedge clock);
    check("done_pulse", {31'd0, tx_done}, 32'd0);
  endtask

  // Absolute time bound so the run always ends.
  initial begin
    #5_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    repeat (4) @(negedge clock);
    check("in_reset_outputs", {27'd0, tx_busy, tx_done, tx_error, ps2_clock_oe, ps2_data_oe}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("post_reset_outputs", {27'd0, tx_busy, tx_done, tx_error, ps2_clock_oe, ps2_data_oe}, 32'd0);

    run_frame(8'hED, 1'b1, 0);
    run_frame(8'h01, 1'b0, 0);
    run_frame(8'hA5, 1'b1, 4);
    repeat (5) @(negedge clock);
    run_frame(8'h3C, 1'b1, 1);
    run_frame(8'h12, 1'b1, 0);
    run_frame(8'h96, 1'b1, 3);
    run_frame(8'hFF, 1'b1, 0);
    run_frame(8'h5A, 1'b1, 2);
    for (int i = 0; i < 6; i++) begin
      run_frame(8'($urandom), 1'($urandom_range(0, 1)), 0);
      repeat (int'($urandom_range(0, 4))) @(negedge clock);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
